// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : Parametrised multi-read-port register file with optional
//                write-to-read bypass, optional hardwired-zero R0, a
//                per-register busy scoreboard for hazard detection and a
//                sequential scrub engine that zeroes one entry per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 4,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic                  CLK,
    input  logic                  C,
    input  logic [NRD*ADDR_W-1:0] RA,
    output logic [NRD*WIDTH-1:0]  BusR,
    output logic [NRD-1:0]        BusyR,
    input  logic [ADDR_W-1:0]     RW,
    input  logic                  RegW,
    input  logic [WIDTH-1:0]      BusW,
    input  logic                  Issue,
    input  logic [ADDR_W-1:0]     IRd,
    input  logic                  Scrub,
    output logic                  Ready,
    output logic                  Done
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SCRUB = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];

    logic                w_idle;
    logic                w_wr_en;
    logic                w_iss_en;

    // Writes and issues are only honoured in IDLE; with ZERO_R0 any access
    // targeting register 0 is silently discarded.
    assign w_idle   = (state_q == ST_IDLE);
    assign w_wr_en  = w_idle && RegW  && !((ZERO_R0 != 0) && (RW  == '0));
    assign w_iss_en = w_idle && Issue && !((ZERO_R0 != 0) && (IRd == '0));

    // Control state, scrub counter and scoreboard; reset overrides everything.
    always_ff @(posedge CLK) begin
        if (!C) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic for the IDLE/SCRUB machine plus the Ready/Done flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        Ready   = 1'b0;
        Done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                Ready = 1'b1;
                if (Scrub) begin
                    state_d = ST_SCRUB;
                    cnt_d   = '0;
                end
            end
            ST_SCRUB: begin
                // Compare before incrementing so the index never leaves range.
                if (cnt_q == LAST_IDX) begin
                    Done    = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Scoreboard update: clear on writeback, then set on issue so a new
    // producer to the same register stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (state_q == ST_SCRUB) begin
            busy_d[cnt_q] = 1'b0;
        end else begin
            if (RegW) begin
                busy_d[RW] = 1'b0;
            end
            if (w_iss_en) begin
                busy_d[IRd] = 1'b1;
            end
        end
        if (ZERO_R0 != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Register array: reset clears all entries, scrub clears one per cycle.
    always_ff @(posedge CLK) begin
        if (!C) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            mem_q[RW] <= BusW;
        end else if (state_q == ST_SCRUB) begin
            mem_q[cnt_q] <= '0;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [WIDTH-1:0]  w_data;
        logic              w_busy;

        assign w_ra = RA[k*ADDR_W +: ADDR_W];

        // Combinational read with optional forwarding of the in-flight write;
        // a forwarded write reports not-busy unless re-issued this same cycle.
        always_comb begin
            w_data = mem_q[w_ra];
            w_busy = busy_q[w_ra];
            if ((BYPASS != 0) && w_idle && RegW && (RW == w_ra)) begin
                w_data = BusW;
                w_busy = Issue && (IRd == w_ra);
            end
            if ((ZERO_R0 != 0) && (w_ra == '0)) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign BusR[k*WIDTH +: WIDTH] = w_data;
        assign BusyR[k]               = w_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_mp
//  Description : Self-checking bench for reg_file_mp. Two instances share
//                stimulus: A (bypass, normal R0) and B (no bypass, zero R0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        C;
    logic [7:0]  RA;
    logic [3:0]  RW;
    logic        RegW;
    logic [31:0] BusW;
    logic        Issue;
    logic [3:0]  IRd;
    logic        Scrub;

    logic [63:0] busr_a, busr_b;
    logic [1:0]  busyr_a, busyr_b;
    logic        ready_a, ready_b, done_a, done_b;

    always #5 CLK = ~CLK;

    reg_file_mp #(.WIDTH(32), .ADDR_W(4), .NRD(2), .BYPASS(1), .ZERO_R0(0)) dut_a (
        .CLK(CLK), .C(C), .RA(RA), .BusR(busr_a), .BusyR(busyr_a), .RW(RW),
        .RegW(RegW), .BusW(BusW), .Issue(Issue), .IRd(IRd), .Scrub(Scrub),
        .Ready(ready_a), .Done(done_a)
    );

    reg_file_mp #(.WIDTH(32), .ADDR_W(4), .NRD(2), .BYPASS(0), .ZERO_R0(1)) dut_b (
        .CLK(CLK), .C(C), .RA(RA), .BusR(busr_b), .BusyR(busyr_b), .RW(RW),
        .RegW(RegW), .BusW(BusW), .Issue(Issue), .IRd(IRd), .Scrub(Scrub),
        .Ready(ready_b), .Done(done_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_mem  [2][DEPTH];
    logic        m_busy [2][DEPTH];
    int          m_left [2];               // scrub cycles still to run, 0 = idle
    int          m_bp   [2] = '{1, 0};
    int          m_zr   [2] = '{0, 1};

    function automatic logic [31:0] exp_data(input int d, input logic [3:0] a);
        if (m_zr[d] != 0 && a == 4'd0) return 32'd0;
        if (m_left[d] == 0 && m_bp[d] != 0 && RegW && RW == a) return BusW;
        return m_mem[d][a];
    endfunction

    function automatic logic exp_busy(input int d, input logic [3:0] a);
        if (m_zr[d] != 0 && a == 4'd0) return 1'b0;
        if (m_left[d] == 0 && m_bp[d] != 0 && RegW && RW == a) return Issue && (IRd == a);
        return m_busy[d][a];
    endfunction

    task automatic model_update();
        int idx;
        for (int d = 0; d < 2; d++) begin
            if (!C) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[d][i]  = 32'd0;
                    m_busy[d][i] = 1'b0;
                end
                m_left[d] = 0;
            end else if (m_left[d] > 0) begin
                idx = DEPTH - m_left[d];
                m_mem[d][idx]  = 32'd0;
                m_busy[d][idx] = 1'b0;
                m_left[d]--;
            end else begin
                if (RegW) begin
                    if (!(m_zr[d] != 0 && RW == 4'd0)) m_mem[d][RW] = BusW;
                    m_busy[d][RW] = 1'b0;
                end
                if (Issue && !(m_zr[d] != 0 && IRd == 4'd0)) m_busy[d][IRd] = 1'b1;
                if (Scrub) m_left[d] = DEPTH;
            end
        end
    endtask

    task automatic check_model();
        logic [63:0] br;
        logic [1:0]  by;
        logic        rd, dn;
        logic [3:0]  a;
        string       tag;
        for (int d = 0; d < 2; d++) begin
            br  = (d == 0) ? busr_a  : busr_b;
            by  = (d == 0) ? busyr_a : busyr_b;
            rd  = (d == 0) ? ready_a : ready_b;
            dn  = (d == 0) ? done_a  : done_b;
            tag = (d == 0) ? "A" : "B";
            for (int k = 0; k < 2; k++) begin
                a = RA[k*4 +: 4];
                chk($sformatf("%s.BusR%0d", tag, k), br[k*32 +: 32], exp_data(d, a));
                chk($sformatf("%s.BusyR%0d", tag, k), {31'd0, by[k]}, {31'd0, exp_busy(d, a)});
            end
            chk($sformatf("%s.Ready", tag), {31'd0, rd}, {31'd0, (m_left[d] == 0)});
            chk($sformatf("%s.Done", tag),  {31'd0, dn}, {31'd0, (m_left[d] == 1)});
        end
    endtask

    task automatic to_sample();
        @(negedge CLK);
        check_model();
    endtask

    task automatic to_edge();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        C = 1'b1; RegW = 1'b0; Issue = 1'b0; Scrub = 1'b0;
        RW = 4'd0; IRd = 4'd0; BusW = 32'd0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < DEPTH; i++) begin
            C = 1'b1; RegW = 1'b1; RW = 4'(i);
            BusW = 32'hA000_0001 + 32'(i) * 32'h0101;
            Issue = 1'b1; IRd = 4'(15 - i);
            to_sample(); to_edge();
        end
        idle_inputs();
    endtask

    // ---------------- directed vector table (instance A) ----------------
    typedef struct {
        logic        c;
        logic        regw;
        logic        issue;
        logic [3:0]  rw;
        logic [3:0]  ird;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [31:0] busw;
        logic [31:0] e_r0;
        logic [31:0] e_r1;
        logic [1:0]  e_busy;
    } vec_t;

    vec_t tbl [11];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int cycles, done_cnt, done_at;
        bit seen_idle;

        tbl[0]  = '{c:1, regw:1, issue:0, rw:5, ird:0, ra0:5, ra1:3, busw:32'hDEADBEEF, e_r0:32'hDEADBEEF, e_r1:32'h0,        e_busy:2'b00};
        tbl[1]  = '{c:1, regw:0, issue:0, rw:0, ird:0, ra0:5, ra1:3, busw:32'h0,        e_r0:32'hDEADBEEF, e_r1:32'h0,        e_busy:2'b00};
        tbl[2]  = '{c:1, regw:1, issue:0, rw:3, ird:0, ra0:5, ra1:3, busw:32'h12345678, e_r0:32'hDEADBEEF, e_r1:32'h12345678, e_busy:2'b00};
        tbl[3]  = '{c:1, regw:0, issue:1, rw:0, ird:7, ra0:7, ra1:3, busw:32'h0,        e_r0:32'h0,        e_r1:32'h12345678, e_busy:2'b00};
        tbl[4]  = '{c:1, regw:0, issue:0, rw:0, ird:0, ra0:7, ra1:7, busw:32'h0,        e_r0:32'h0,        e_r1:32'h0,        e_busy:2'b11};
        tbl[5]  = '{c:1, regw:1, issue:1, rw:7, ird:7, ra0:7, ra1:5, busw:32'hA5A5A5A5, e_r0:32'hA5A5A5A5, e_r1:32'hDEADBEEF, e_busy:2'b01};
        tbl[6]  = '{c:1, regw:0, issue:0, rw:0, ird:0, ra0:7, ra1:7, busw:32'h0,        e_r0:32'hA5A5A5A5, e_r1:32'hA5A5A5A5, e_busy:2'b11};
        tbl[7]  = '{c:1, regw:1, issue:0, rw:7, ird:0, ra0:7, ra1:3, busw:32'h0BADF00D, e_r0:32'h0BADF00D, e_r1:32'h12345678, e_busy:2'b00};
        tbl[8]  = '{c:1, regw:0, issue:0, rw:0, ird:0, ra0:7, ra1:7, busw:32'h0,        e_r0:32'h0BADF00D, e_r1:32'h0BADF00D, e_busy:2'b00};
        tbl[9]  = '{c:0, regw:0, issue:0, rw:0, ird:0, ra0:5, ra1:7, busw:32'h0,        e_r0:32'hDEADBEEF, e_r1:32'h0BADF00D, e_busy:2'b00};
        tbl[10] = '{c:1, regw:0, issue:0, rw:0, ird:0, ra0:5, ra1:7, busw:32'h0,        e_r0:32'h0,        e_r1:32'h0,        e_busy:2'b00};

        idle_inputs();
        C  = 1'b0;
        RA = 8'd0;
        to_edge(); to_edge();
        C = 1'b1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            C = tbl[i].c; RegW = tbl[i].regw; Issue = tbl[i].issue;
            RW = tbl[i].rw; IRd = tbl[i].ird; BusW = tbl[i].busw; Scrub = 1'b0;
            RA = {tbl[i].ra1, tbl[i].ra0};
            to_sample();
            chk($sformatf("tbl%0d.BusR0", i), busr_a[31:0],  tbl[i].e_r0);
            chk($sformatf("tbl%0d.BusR1", i), busr_a[63:32], tbl[i].e_r1);
            chk($sformatf("tbl%0d.BusyR", i), {30'd0, busyr_a}, {30'd0, tbl[i].e_busy});
            chk($sformatf("tbl%0d.Ready", i), {31'd0, ready_a}, 32'd1);
            to_edge();
        end

        // No-bypass instance: old value this cycle, new value next cycle
        idle_inputs();
        RegW = 1'b1; RW = 4'd3; BusW = 32'h12345678; RA = {4'd3, 4'd3};
        to_sample();
        chk("nobyp.same_cycle", busr_b[63:32], 32'h0);
        chk("byp.same_cycle",   busr_a[63:32], 32'h12345678);
        to_edge();
        idle_inputs();
        to_sample();
        chk("nobyp.next_cycle", busr_b[63:32], 32'h12345678);
        to_edge();

        // Hardwired zero R0 on instance B
        RegW = 1'b1; RW = 4'd0; BusW = 32'hFFFFFFFF; Issue = 1'b1; IRd = 4'd0; RA = 8'h00;
        to_sample();
        chk("zr0.data_same", busr_b[31:0] | busr_b[63:32], 32'h0);
        chk("zr0.busy_same", {30'd0, busyr_b}, 32'h0);
        to_edge();
        idle_inputs();
        to_sample();
        chk("zr0.data_next", busr_b[31:0] | busr_b[63:32], 32'h0);
        chk("zr0.busy_next", {30'd0, busyr_b}, 32'h0);
        chk("r0.a_data_next", busr_a[31:0], 32'hFFFFFFFF);
        to_edge();

        // Full scrub with a same-cycle write and a mid-scrub write/issue/restart
        fill_all();
        RegW = 1'b1; RW = 4'd4; BusW = 32'hCAFE0004; Scrub = 1'b1;
        to_sample(); to_edge();
        idle_inputs();
        cycles = 0; done_cnt = 0; done_at = -1; seen_idle = 1'b0;
        for (int t = 0; t < 40; t++) begin
            idle_inputs();
            if (t == 3) begin
                RegW = 1'b1; RW = 4'd2; BusW = 32'hFFFF0002;
                Issue = 1'b1; IRd = 4'd2; Scrub = 1'b1;
            end
            to_sample();
            if (!ready_a) begin
                cycles++;
                if (done_a) begin
                    done_cnt++;
                    done_at = cycles;
                end
            end else begin
                seen_idle = 1'b1;
            end
            to_edge();
            if (seen_idle) break;
        end
        chk("scrub.busy_cycles", 32'(cycles),   32'd16);
        chk("scrub.done_count",  32'(done_cnt), 32'd1);
        chk("scrub.done_cycle",  32'(done_at),  32'd16);
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            RA = {4'(2*i+1), 4'(2*i)};
            to_sample();
            chk($sformatf("scrub.readA%0d", i), busr_a[31:0] | busr_a[63:32], 32'h0);
            chk($sformatf("scrub.readB%0d", i), busr_b[31:0] | busr_b[63:32], 32'h0);
            chk($sformatf("scrub.busyA%0d", i), {30'd0, busyr_a}, 32'h0);
            to_edge();
        end

        // Reset in the middle of a scrub
        fill_all();
        Scrub = 1'b1;
        to_sample(); to_edge();
        idle_inputs();
        for (int s = 1; s <= 5; s++) begin
            to_sample(); to_edge();
        end
        C = 1'b0;
        to_sample(); to_edge();
        idle_inputs();
        RegW = 1'b1; RW = 4'd9; BusW = 32'h99999999; RA = {4'd0, 4'd9};
        to_sample();
        chk("rst.ready", {31'd0, ready_a}, 32'd1);
        chk("rst.done",  {31'd0, done_a},  32'd0);
        chk("rst.byp9",  busr_a[31:0], 32'h99999999);
        to_edge();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            RA = {4'(2*i+1), 4'(2*i)};
            to_sample();
            chk($sformatf("rst.readA%0d", 2*i),   busr_a[31:0],  (2*i == 9)   ? 32'h99999999 : 32'h0);
            chk($sformatf("rst.readA%0d", 2*i+1), busr_a[63:32], (2*i+1 == 9) ? 32'h99999999 : 32'h0);
            to_edge();
        end

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            C     = ($urandom_range(0, 99) != 0);
            RegW  = $urandom_range(0, 1) == 1;
            RW    = 4'($urandom_range(0, 15));
            BusW  = $urandom;
            Issue = $urandom_range(0, 2) == 0;
            IRd   = ($urandom_range(0, 3) == 0) ? RW : 4'($urandom_range(0, 15));
            Scrub = ($urandom_range(0, 39) == 0);
            RA[3:0] = ($urandom_range(0, 2) == 0) ? RW : 4'($urandom_range(0, 15));
            RA[7:4] = ($urandom_range(0, 2) == 0) ? IRd : 4'($urandom_range(0, 15));
            to_sample(); to_edge();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-read-port register file, the successor to the current 16x32 two-read/one-write file. Adds configurable width, depth and read-port count, optional write-to-read bypass, an optional hardwired-zero R0, and a per-register busy scoreboard for pipeline hazard detection. Also adds a sequential scrub engine that zeroes the array one entry per cycle. Sits in the decode stage; the write port is fed from writeback.

Parameters:
WIDTH, 32, data width of each register
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports
ZERO_R0, 0, 1 = register 0 reads 0, ignores writes and is never busy

Ports:
CLK  input  1  clock; all state updates on the rising edge
C  input  1  reset: synchronous, active-low
RA  input  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
BusR  output  NRD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH]
BusyR  output  NRD  busy flag of the register addressed by read port k
RW  input  ADDR_W  write address
RegW  input  1  write enable
BusW  input  WIDTH  write data
Issue  input  1  marks register IRd busy (a new in-flight producer)
IRd  input  ADDR_W  destination register being issued
Scrub  input  1  start request for a sequential zero-fill
Ready  output  1  1 = IDLE; writes and issues are accepted
Done  output  1  one-cycle pulse on the final scrub cycle

Behaviour:
- Reset (C=0 at a rising edge): all registers = 0, busy[] = 0, FSM = IDLE, scrub counter = 0, Ready = 1, Done = 0. Reset takes priority over every other input, including mid-scrub.
- Reads are combinational from the array, with zero added latency.
- Bypass: if BYPASS=1, Ready=1, RegW=1 and RW==RA_k, then BusR_k = BusW in the same cycle. If BYPASS=0, the read returns the old value and the new value is visible the cycle after the edge.
- Write: when RegW=1 and Ready=1, reg[RW] <= BusW at the edge.
- ZERO_R0=1:
  - BusR_k = 0 whenever RA_k = 0, with or without bypass.
  - Writes to register 0 are dropped.
  - busy[0] is held at 0.
- Scoreboard, per register in IDLE:
  - Issue with IRd=r sets busy[r].
  - RegW with RW=r clears busy[r].
  - Issue and RegW to the same r in the same cycle: set wins, busy[r]=1 (the new producer is still outstanding).
  - Issue and RegW to different registers apply independently.
- BusyR_k = busy[RA_k]. If BYPASS=1 and a write to RA_k is happening this cycle, BusyR_k = 0, unless Issue targets the same register in that cycle, in which case BusyR_k = 1.
- FSM states: IDLE and SCRUB.
  - IDLE -> SCRUB when Scrub=1. The counter loads 0.
  - In SCRUB, each cycle: reg[cnt] <= 0, busy[cnt] <= 0, cnt <= cnt+1. Ready = 0.
  - When cnt == DEPTH-1: Done = 1 that cycle; next state is IDLE and the counter returns to 0.
  - Total scrub time is exactly DEPTH cycles. Ready rises on the cycle after Done.
  - Scrub=1 while in SCRUB is ignored; no restart.
  - Scrub=1 in the same IDLE cycle as RegW/Issue: that cycle's write and issue are performed, then SCRUB begins. Scrub later zeroes that write.
- During SCRUB:
  - RegW and Issue are dropped, with no side effects.
  - Reads return current array contents; no bypass is applied.
  - BusyR reflects the busy bits as they are being cleared.
- Address wrap: the counter is ADDR_W+1 bits wide or is compared before incrementing. No out-of-range index is ever used.

Test Plan:
- Reset, then write reg5=0xDEADBEEF; next cycle RA0=5 -> BusR0=0xDEADBEEF. Assert C=0 -> next cycle BusR0=0.
- BYPASS=1, RegW=1, RW=3, BusW=0x12345678, RA1=3 in the same cycle -> BusR1=0x12345678 and BusyR1=0 that cycle. Repeat with BYPASS=0 -> old value 0 that cycle, new value the next cycle.
- Issue IRd=7 -> BusyR=1 for RA=7 from the next cycle. Same-cycle Issue IRd=7 and RegW RW=7 -> busy[7] stays 1. A later RegW RW=7 -> busy[7]=0.
- ZERO_R0=1: write 0xFFFFFFFF to reg0 and Issue IRd=0 -> BusR=0 and BusyR=0 for RA=0 on all ports.
- Fill all 16 registers with nonzero values, pulse Scrub -> Ready=0 for exactly 16 cycles, Done high only on the 16th. Every register reads 0 afterwards. A RegW issued mid-scrub leaves no trace.
- Assert C=0 at cycle 6 of a scrub -> next cycle Ready=1, Done=0, all registers 0, FSM accepts a new write immediately.
